// File: rtl/ahb_dual_sram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ahb_dual_sram_arbiter                                    |
// | Description : Two AHB-Lite slave ports (imem, dmem) sharing one        |
// |               single-port SRAM. Each port holds a one-entry pending    |
// |               register; conflicts are resolved by round-robin.         |
// |               Optional macro AHB_ARB_ALIGN_ERR_EN adds misaligned-     |
// |               access ERROR responses.                                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ahb_dual_sram_arbiter #(
   parameter int ADDR_W      = 12,
   parameter bit FIRST_GRANT = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              imem_hsel,
   input  logic [31:0]       imem_haddr,
   input  logic [1:0]        imem_htrans,
   input  logic              imem_hwrite,
   input  logic [2:0]        imem_hsize,
   input  logic [31:0]       imem_hwdata,
   output logic [31:0]       imem_hrdata,
   output logic              imem_hready,
   output logic              imem_hresp,
   input  logic              dmem_hsel,
   input  logic [31:0]       dmem_haddr,
   input  logic [1:0]        dmem_htrans,
   input  logic              dmem_hwrite,
   input  logic [2:0]        dmem_hsize,
   input  logic [31:0]       dmem_hwdata,
   output logic [31:0]       dmem_hrdata,
   output logic              dmem_hready,
   output logic              dmem_hresp,
   output logic              mem_en,
   output logic              mem_rwn,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wben,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // Port index 0 = imem, 1 = dmem (matches FIRST_GRANT / last_grant encoding)
   logic [1:0]                 w_act;
   logic [1:0][ADDR_W+1:0]     w_haddr;
   logic [1:0]                 w_hwrite;
   logic [1:0][2:0]            w_hsize;
   logic [1:0][31:0]           w_hwdata;

   logic [1:0]                 r_valid;
   logic [1:0][ADDR_W+1:0]     r_addr;
   logic [1:0]                 r_write;
   logic [1:0][2:0]            r_size;
   logic                       r_last_grant;

   logic [1:0]                 w_req;
   logic [1:0]                 w_serve;
   logic [1:0]                 w_rdy;
   logic [1:0]                 w_resp;
   logic [1:0]                 w_capture;
   logic                       w_any;
   logic                       w_sel;
   logic [1:0]                 w_lo;
   logic [3:0]                 w_wben;
   logic                       w_unused_ok;

   assign w_act    = {dmem_hsel & dmem_htrans[1], imem_hsel & imem_htrans[1]};
   assign w_haddr  = {dmem_haddr[ADDR_W+1:0], imem_haddr[ADDR_W+1:0]};
   assign w_hwrite = {dmem_hwrite, imem_hwrite};
   assign w_hsize  = {dmem_hsize, imem_hsize};
   assign w_hwdata = {dmem_hwdata, imem_hwdata};

   assign w_unused_ok = &{1'b0, imem_haddr[31:ADDR_W+2], dmem_haddr[31:ADDR_W+2],
                          imem_htrans[0], dmem_htrans[0]};

`ifdef AHB_ARB_ALIGN_ERR_EN
   logic [1:0] r_mis;
   logic [1:0] r_eph;
   logic [1:0] w_err;

   function automatic logic f_misaligned(input logic [1:0] a, input logic [2:0] s);
      return ((s == 3'd1) && a[0]) || ((s >= 3'd2) && (a != 2'b00));
   endfunction

   // Error entries never compete for the SRAM; r_eph marks the second ERROR cycle
   assign w_err  = r_valid & r_mis;
   assign w_req  = r_valid & ~r_mis;
   assign w_rdy  = (w_err & r_eph) | (~w_err & (~r_valid | w_serve));
   assign w_resp = w_err;
`else
   assign w_req  = r_valid;
   assign w_rdy  = ~r_valid | w_serve;
   assign w_resp = 2'b00;
`endif

   // On a tie, the master that did not win last time goes first
   assign w_serve[0] = w_req[0] & (~w_req[1] | r_last_grant);
   assign w_serve[1] = w_req[1] & (~w_req[0] | ~r_last_grant);
   assign w_capture  = w_act & w_rdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid      <= 2'b00;
         r_last_grant <= ~FIRST_GRANT;
`ifdef AHB_ARB_ALIGN_ERR_EN
         r_mis        <= 2'b00;
         r_eph        <= 2'b00;
`endif
      end else begin
         if (|w_serve) begin
            r_last_grant <= w_serve[1];
         end
         for (int p = 0; p < 2; p++) begin
            if (w_capture[p]) begin
               r_valid[p] <= 1'b1;
               r_addr[p]  <= w_haddr[p];
               r_write[p] <= w_hwrite[p];
               r_size[p]  <= w_hsize[p];
`ifdef AHB_ARB_ALIGN_ERR_EN
               r_mis[p]   <= f_misaligned(w_haddr[p][1:0], w_hsize[p]);
               r_eph[p]   <= 1'b0;
            end else if (w_err[p]) begin
               r_eph[p]   <= ~r_eph[p];
               if (r_eph[p]) begin
                  r_valid[p] <= 1'b0;
               end
`endif
            end else if (w_serve[p]) begin
               r_valid[p] <= 1'b0;
            end
         end
      end
   end

   assign w_any = (|w_serve) & ~reset;
   assign w_sel = w_serve[1];
   assign w_lo  = r_addr[w_sel][1:0];

   always_comb begin
      w_wben = 4'b0000;
      if (w_any && r_write[w_sel]) begin
         case (r_size[w_sel])
            3'b000:  w_wben = 4'b0001 << w_lo;
            3'b001:  w_wben = w_lo[1] ? 4'b1100 : 4'b0011;
            default: w_wben = 4'b1111;
         endcase
      end
   end

   assign mem_en    = w_any;
   assign mem_rwn   = w_any ? ~r_write[w_sel] : 1'b1;
   assign mem_addr  = w_any ? r_addr[w_sel][ADDR_W+1:2] : '0;
   assign mem_wben  = w_wben;
   assign mem_wdata = w_any ? w_hwdata[w_sel] : 32'h0;

   assign imem_hready = reset | w_rdy[0];
   assign dmem_hready = reset | w_rdy[1];
   assign imem_hresp  = ~reset & w_resp[0];
   assign dmem_hresp  = ~reset & w_resp[1];
   assign imem_hrdata = (w_serve[0] && !reset) ? mem_rdata : 32'h0;
   assign dmem_hrdata = (w_serve[1] && !reset) ? mem_rdata : 32'h0;

endmodule
`default_nettype wire
